// File: rtl/mk8_param_page_writer.sv
// Parameter page writer: queues {addr,data} commands, writes each to an Avalon-MM slave,
// reads it back and flags the first address whose readback does not match.
module mk8_param_page_writer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [15:0]       cmd_data,
    output logic              cmd_ready,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write_n,
    output logic              read_n,
    output logic [31:0]       writedata,
    input  logic [31:0]       readdata,
    input  logic              waitrequest,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, CHECK} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W+15:0]  fifo_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [ADDR_W-1:0]   addr_q, err_addr_q;
    logic [15:0]         data_q;
    logic [31:0]         rdata_q;
    logic                done_q, err_q;
    logic                push, pop, full, empty, match;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state_q == IDLE) && !empty;
    assign match     = (rdata_q == {16'b0, data_q});

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {cmd_addr, cmd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!empty) state_d = WRITE;
            WRITE:   if (!waitrequest) state_d = READ;
            READ:    if (!waitrequest) state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Working registers hold the command steady for the whole write/read pair.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q     <= '0;
            data_q     <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (pop) begin
                {addr_q, data_q} <= fifo_q[rd_ptr_q];
            end
            if (state_q == READ && !waitrequest) begin
                rdata_q <= readdata;
            end
            if (state_q == CHECK) begin
                if (match) begin
                    done_q <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                    if (!err_q) begin
                        err_addr_q <= addr_q;
                    end
                end
            end
        end
    end

    assign chipselect = (state_q == WRITE) || (state_q == READ);
    assign write_n    = (state_q != WRITE);
    assign read_n     = (state_q != READ);
    assign address    = addr_q;
    assign writedata  = {16'b0, data_q};
    assign busy       = !empty || (state_q != IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_mk8_param_page_writer.sv
// Scoreboard bench for mk8_param_page_writer: a slave model answers the bus, expected
// commands are queued at push time and a negedge monitor checks bus traffic and results.
module tb_mk8_param_page_writer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } cmd_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic [ADDR_W-1:0] cmd_addr;
    logic [15:0]       cmd_data;
    logic              cmd_ready;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic              read_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              waitrequest;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] err_addr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Scoreboard and slave-model state
    cmd_t              expQ[$];
    logic              corruptPlan[$];
    cmd_t              cur;
    int                phase = 0;
    logic              inXfer = 1'b0;
    int                waitLeft = 0;
    logic              stallAll = 1'b0;
    logic              stallRead = 1'b0;
    logic              randWaits = 1'b0;
    int                fixedW = 0;
    int                corruptPct = 0;
    logic              aValid = 1'b0, aPass = 1'b0, bValid = 1'b0, bPass = 1'b0;
    logic [ADDR_W-1:0] aAddr = '0, bAddr = '0;
    logic              visErr = 1'b0;
    logic [ADDR_W-1:0] visErrAddr = '0;
    int                lastWrCyc = 0, lastDoneCyc = 0, lastPushCyc = 0;

    mk8_param_page_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .read_n      (read_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_addr    (err_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Offer one command; assumes the caller is just after a rising edge.
    task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        logic got;
        got = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                lastPushCyc = cyc;
            end
            @(posedge clk);
            if (got) expQ.push_back('{addr: a, data: d});
        end
        #1;
        cmd_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: got no cmd_ready expected cmd_ready=1");
        end
    endtask

    task automatic waitDrain();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 3000 && !idle; i++) begin
            @(negedge clk);
            idle = !busy && (expQ.size() == 0);
        end
        repeat (3) @(negedge clk);
        if (!idle) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got busy=%0b queued=%0d expected idle", busy, expQ.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues();
        checkOutput("rst_chipselect", 32'(chipselect), 32'd0);
        checkOutput("rst_write_n", 32'(write_n), 32'd1);
        checkOutput("rst_read_n", 32'(read_n), 32'd1);
        checkOutput("rst_address", 32'(address), 32'd0);
        checkOutput("rst_writedata", writedata, 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_err_addr", 32'(err_addr), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    // Monitor + slave model: each falling edge checks done/err against the delayed
    // readback verdicts, answers the bus, and checks every bus cycle against the queue.
    always @(negedge clk) begin
        logic accepted;
        logic corrupt;
        logic [31:0] good;
        if (!reset_n) begin
            expQ.delete();
            corruptPlan.delete();
            phase = 0;
            inXfer = 1'b0;
            aValid = 1'b0;
            bValid = 1'b0;
            visErr = 1'b0;
            visErrAddr = '0;
            waitrequest = 1'b0;
        end else begin
            if (bValid && !bPass && !visErr) begin
                visErr = 1'b1;
                visErrAddr = bAddr;
            end
            checkOutput("done", 32'(done), 32'(bValid && bPass));
            checkOutput("err", 32'(err), 32'(visErr));
            checkOutput("err_addr", 32'(err_addr), 32'(visErrAddr));
            if (done) lastDoneCyc = cyc;
            bValid = aValid;
            bPass = aPass;
            bAddr = aAddr;
            aValid = 1'b0;

            accepted = 1'b0;
            readdata = $urandom;
            if (chipselect) begin
                if (!inXfer) begin
                    inXfer = 1'b1;
                    waitLeft = randWaits ? int'($urandom_range(0, 2)) : fixedW;
                end
                if (stallAll || (stallRead && !read_n)) begin
                    waitrequest = 1'b1;
                end else if (waitLeft > 0) begin
                    waitrequest = 1'b1;
                    waitLeft--;
                end else begin
                    waitrequest = 1'b0;
                    accepted = 1'b1;
                    inXfer = 1'b0;
                end
            end else begin
                waitrequest = 1'($urandom_range(0, 1));
                inXfer = 1'b0;
            end

            if (chipselect) begin
                if (phase == 0) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_write", 32'(write_n), 32'd1);
                    end else begin
                        checkOutput("wr_write_n", 32'(write_n), 32'd0);
                        checkOutput("wr_read_n", 32'(read_n), 32'd1);
                        checkOutput("wr_address", 32'(address), 32'(expQ[0].addr));
                        checkOutput("wr_writedata", writedata, {16'b0, expQ[0].data});
                        if (accepted) begin
                            cur = expQ.pop_front();
                            phase = 1;
                            lastWrCyc = cyc;
                        end
                    end
                end else begin
                    checkOutput("rd_read_n", 32'(read_n), 32'd0);
                    checkOutput("rd_write_n", 32'(write_n), 32'd1);
                    checkOutput("rd_address", 32'(address), 32'(cur.addr));
                    if (accepted) begin
                        good = {16'b0, cur.data};
                        if (corruptPlan.size() > 0) corrupt = corruptPlan.pop_front();
                        else corrupt = ($urandom_range(0, 99) < corruptPct);
                        if (!corrupt) readdata = good;
                        else if (corruptPlan.size() == 0 && corruptPct > 0)
                            readdata = good ^ (32'h1 << $urandom_range(0, 31));
                        else readdata = (good == 32'h0000_5678) ? 32'h0000_5679 : 32'h0000_5678;
                        aValid = 1'b1;
                        aPass = !corrupt;
                        aAddr = cur.addr;
                        phase = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic sawRead;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        readdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single zero-wait command: write, read back, done four cycles after the pop
        applyStimulus(2'd0, 16'h1234);
        waitDrain();
        checkOutput("lat_write_to_done", 32'(lastDoneCyc - lastWrCyc), 32'd3);
        checkOutput("lat_push_to_done", 32'(lastDoneCyc - lastPushCyc), 32'd5);
        checkOutput("err_after_pass", 32'(err), 32'd0);

        // Three wait states on every transfer; monitor checks the bus holds steady
        fixedW = 3;
        applyStimulus(2'd3, 16'hBEEF);
        waitDrain();
        checkOutput("lat_waits_write_to_done", 32'(lastDoneCyc - lastWrCyc), 32'd6);
        fixedW = 0;

        // Fill the FIFO behind a stalled write, then one more must wait for space
        stallAll = 1'b1;
        applyStimulus(2'd1, 16'h0101);
        applyStimulus(2'd2, 16'h0202);
        applyStimulus(2'd3, 16'h0303);
        applyStimulus(2'd0, 16'h0404);
        applyStimulus(2'd1, 16'h0505);
        @(negedge clk);
        checkOutput("full_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        fork
            applyStimulus(2'd2, 16'h0606);
            begin
                repeat (5) @(negedge clk);
                checkOutput("full_held_cmd_ready", 32'(cmd_ready), 32'd0);
                stallAll = 1'b0;
            end
        join
        waitDrain();

        // Two bad readbacks: err latches the first address only, no done pulses
        corruptPlan.push_back(1'b1);
        corruptPlan.push_back(1'b1);
        applyStimulus(2'd2, 16'h1234);
        applyStimulus(2'd1, 16'h00AA);
        waitDrain();
        checkOutput("mismatch_err", 32'(err), 32'd1);
        checkOutput("mismatch_err_addr", 32'(err_addr), 32'd2);
        applyStimulus(2'd3, 16'h7777);
        waitDrain();
        checkOutput("err_sticky_addr", 32'(err_addr), 32'd2);

        // Randomized traffic with random wait states and occasional corruption
        randWaits = 1'b1;
        corruptPct = 15;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            applyStimulus(ADDR_W'($urandom), 16'($urandom));
        end
        waitDrain();
        randWaits = 1'b0;
        corruptPct = 0;

        // Reset during a stalled read with two commands still queued
        stallRead = 1'b1;
        applyStimulus(2'd1, 16'hAAAA);
        applyStimulus(2'd2, 16'hBBBB);
        applyStimulus(2'd3, 16'hCCCC);
        sawRead = 1'b0;
        for (int i = 0; i < 200 && !sawRead; i++) begin
            @(negedge clk);
            sawRead = chipselect && !read_n;
        end
        checkOutput("reached_read", 32'(sawRead), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkResetValues();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        stallRead = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(2'd0, 16'h4242);
        waitDrain();
        checkOutput("post_reset_err", 32'(err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
